// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern, overlap control,
// a one-cycle registered match pulse and a saturating match counter.
module seq_detect_param #(
  parameter int PAT_WIDTH = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Din,
  input  logic                 Din_valid,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic                 pat_load,
  input  logic                 overlap,
  input  logic                 cnt_clr,
  output logic                 Dout,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 busy
);

  localparam int FW = $clog2(PAT_WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_WIDTH);
  localparam logic [FW-1:0] LAST = FW'(PAT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } state_t;

  state_t                 state_q, state_d;
  logic [PAT_WIDTH-1:0]   win_q, win_d;
  logic [PAT_WIDTH-1:0]   pat_q, pat_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   dout_q, dout_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [PAT_WIDTH-1:0]   win_nx;
  logic                   take;
  logic                   hit;

  assign win_nx = {win_q[PAT_WIDTH-2:0], Din};
  assign take   = Din_valid && !pat_load && (state_q != IDLE);
  // The incoming bit completes a full window once PAT_WIDTH-1 bits are held.
  assign hit    = take && (fill_q >= LAST) && (win_nx == pat_q);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    dout_d  = 1'b0;
    cnt_d   = cnt_q;

    if (pat_load) begin
      pat_d   = pattern;
      win_d   = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (hit) begin
      dout_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      if (overlap) begin
        win_d   = win_nx;
        fill_d  = FULL;
        state_d = ARMED;
      end else begin
        win_d   = '0;
        fill_d  = '0;
        state_d = FILL;
      end
    end else if (take) begin
      win_d = win_nx;
      if (fill_q != FULL) begin
        fill_d = fill_q + FW'(1);
      end
      state_d = (fill_d == FULL) ? ARMED : FILL;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      pat_q   <= '0;
      fill_q  <= '0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Dout        = dout_q;
  assign match_count = cnt_q;
  assign busy        = (state_q == FILL) || (state_q == ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a bit-history reference model pushes
// expected outputs per edge; a monitor pops and compares after the edge.
module tb_seq_detect_param;

  localparam int PW = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Din = 1'b0;
  logic          Din_valid = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic          pat_load = 1'b0;
  logic          overlap = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          Dout;
  logic [CW-1:0] match_count;
  logic          busy;

  seq_detect_param #(
    .PAT_WIDTH(PW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Din        (Din),
    .Din_valid  (Din_valid),
    .pattern    (pattern),
    .pat_load   (pat_load),
    .overlap    (overlap),
    .cnt_clr    (cnt_clr),
    .Dout       (Dout),
    .match_count(match_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    dout;
    int    cnt;
    int    busy;
    int    fill;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_loaded = 0;
  bit [PW-1:0] m_pat = '0;
  bit          m_hist[$];
  int          m_cnt = 0;
  bit [PW-1:0] pat_in = '0;

  task automatic drive(input string tag, input bit rst, input bit ld,
                       input bit d, input bit v, input bit ov,
                       input bit clr);
    exp_t e;
    bit   match;
    int   n;
    @(negedge clk);
    Reset     = rst;
    pat_load  = ld;
    pattern   = pat_in;
    Din       = d;
    Din_valid = v;
    overlap   = ov;
    cnt_clr   = clr;
    match = 0;
    if (rst) begin
      m_loaded = 0;
      m_pat    = '0;
      m_hist.delete();
      m_cnt    = 0;
    end else begin
      if (ld) begin
        m_pat    = pat_in;
        m_loaded = 1;
        m_hist.delete();
      end else if (m_loaded && v) begin
        m_hist.push_back(d);
        n = m_hist.size();
        if (n >= PW) begin
          match = 1;
          for (int i = 0; i < PW; i++)
            if (m_hist[n-PW+i] != m_pat[PW-1-i]) match = 0;
        end
        if (match) begin
          if (m_cnt < CMAX) m_cnt++;
          if (!ov) m_hist.delete();
        end
        while (m_hist.size() > PW) void'(m_hist.pop_front());
      end
      if (clr) m_cnt = 0;
    end
    e.tag  = tag;
    e.dout = match ? 1 : 0;
    e.cnt  = m_cnt;
    e.busy = m_loaded ? 1 : 0;
    e.fill = m_hist.size();
    sb.push_back(e);
  endtask

  task automatic bit_in(input string tag, input bit d, input bit ov);
    drive(tag, 0, 0, d, 1, ov, 0);
  endtask

  task automatic load(input string tag, input bit [PW-1:0] p,
                      input bit clr);
    pat_in = p;
    drive(tag, 0, 1, 0, 0, 0, clr);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".dout"}, int'(Dout), e.dout);
      check({e.tag, ".cnt"}, int'(match_count), e.cnt);
      check({e.tag, ".busy"}, int'(busy), e.busy);
      check({e.tag, ".fill"}, int'(dut.fill_q), e.fill);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [6:0] s7;
    bit [15:0] s16;

    drive("reset", 1, 0, 0, 0, 0, 0);
    drive("reset2", 1, 1, 1, 1, 1, 1);
    bit_in("idle_din", 1, 1);

    // Overlapping detect of 1011 in 1011011
    load("ld_ov", 4'b1011, 0);
    s7 = 7'b1011011;
    for (int i = 6; i >= 0; i--) bit_in("ov_stream", s7[i], 1);

    // Non-overlapping: one match, then 3 bits held
    load("ld_nov", 4'b1011, 1);
    for (int i = 6; i >= 0; i--) bit_in("nov_stream", s7[i], 0);

    // 300 ones: counter saturates, pulse every bit from the 4th
    load("ld_ones", 4'b1111, 1);
    for (int i = 0; i < 300; i++) bit_in("ones", 1, 1);

    // Valid gap mid-pattern
    load("ld_gap", 4'b1011, 1);
    bit_in("gap_a", 1, 1);
    bit_in("gap_a", 0, 1);
    bit_in("gap_a", 1, 1);
    for (int i = 0; i < 5; i++) drive("gap_idle", 0, 0, 1, 0, 1, 0);
    bit_in("gap_b", 1, 1);

    // Clear coinciding with a match yields zero
    bit_in("clr_hit", 0, 1);
    bit_in("clr_hit", 1, 1);
    drive("clr_hit", 0, 0, 1, 1, 1, 1);

    // Reload with a valid bit on the same edge discards the bit
    load("ld_rst", 4'b1011, 1);
    bit_in("rl_a", 1, 1);
    bit_in("rl_a", 0, 1);
    bit_in("rl_a", 1, 1);
    drive("rl_load", 0, 1, 1, 1, 1, 0);
    bit_in("rl_b", 1, 0);
    bit_in("rl_b", 0, 0);
    bit_in("rl_b", 1, 0);
    bit_in("rl_b", 1, 0);

    // Pattern input changes without a load are ignored; overlap toggles
    pat_in = 4'b0000;
    s16 = 16'b1011_0110_1101_1011;
    for (int i = 15; i >= 0; i--) bit_in("toggle", s16[i], i[0]);

    // Reset mid-stream after five matches
    load("ld_r", 4'b1011, 1);
    s16 = 16'b1011_0110_1101_1011;
    for (int i = 15; i >= 0; i--) bit_in("five", s16[i], 1);
    bit_in("pre_r", 1, 1);
    bit_in("pre_r", 0, 1);
    bit_in("pre_r", 1, 1);
    drive("midrst", 1, 1, 1, 1, 1, 1);
    bit_in("post_r", 1, 1);
    bit_in("post_r", 0, 1);
    bit_in("post_r", 1, 1);
    bit_in("post_r", 1, 1);

    @(negedge clk);
    Din_valid = 0;
    @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
